alu_frame_ctrl: RTL and testbench

//  Sequencer in front of the combinational ALU. Collects a 3-byte frame (A, B, OP) from an

---
 rtl/alu_frame_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_ctrl.sv
// rtl/alu_frame_ctrl.sv - A/B/OP frame sequencer in front of a combinational ALU
// Optional inter-byte abort timer enabled by `define ALU_CTRL_TIMEOUT_EN.
module alu_frame_ctrl #(
   parameter int nb_data     = 8,
   parameter int nb_timeout  = 16,
   parameter int timeout_cyc = 50000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [nb_data-1:0] i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [nb_data-1:0] o_alu_a,
   output logic [nb_data-1:0] o_alu_b,
   output logic [nb_data-1:0] o_alu_op,
   input  logic [nb_data-1:0] i_alu_res,
   output logic [nb_data-1:0] o_res,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic               o_err,
   output logic [7:0]         o_frame_cnt,
   output logic               o_timeout,
   output logic               o_busy
);

   typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SEND} state_t;

   state_t state, next_state;
   logic   accept;
   logic   exec_settled;
   logic   timeout_hit;

   function automatic logic is_legal(input logic [nb_data-1:0] op);
      case (op)
         8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27: is_legal = 1'b1;
         default:                                                is_legal = 1'b0;
      endcase
   endfunction

   assign accept = i_valid & o_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_A;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_A:    if (accept) next_state = S_B;
         S_B:    if (accept) next_state = S_OP;
                 else if (timeout_hit) next_state = S_A;
         S_OP:   if (accept) next_state = S_EXEC;
                 else if (timeout_hit) next_state = S_A;
         S_EXEC: if (exec_settled) next_state = S_SEND;
         S_SEND: if (i_res_ready) next_state = S_A;
         default: next_state = S_A;
      endcase
   end

   always_comb begin
      o_ready = (state == S_A) || (state == S_B) || (state == S_OP);
      o_busy  = (state != S_A);
   end

   // Result is captured on the second S_EXEC edge so the ALU sees a full cycle of stable operands.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         o_alu_a      <= '0;
         o_alu_b      <= '0;
         o_alu_op     <= '0;
         o_res        <= '0;
         o_res_valid  <= 1'b0;
         o_err        <= 1'b0;
         o_frame_cnt  <= 8'd0;
         exec_settled <= 1'b0;
      end else begin
         exec_settled <= 1'b0;
         case (state)
            S_A:  if (accept) o_alu_a <= i_data;
            S_B:  if (accept) o_alu_b <= i_data;
            S_OP: if (accept) begin
               o_alu_op <= i_data;
               o_err    <= ~is_legal(i_data);
            end
            S_EXEC: if (!exec_settled) begin
               exec_settled <= 1'b1;
            end else begin
               o_res       <= i_alu_res;
               o_res_valid <= 1'b1;
            end
            S_SEND: if (i_res_ready) begin
               o_res_valid <= 1'b0;
               o_err       <= 1'b0;
               o_frame_cnt <= o_frame_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_CTRL_TIMEOUT_EN
   localparam logic [nb_timeout-1:0] timeout_lim = nb_timeout'(timeout_cyc - 1);

   logic [nb_timeout-1:0] idle_cnt;
   logic                  mid_frame;

   assign mid_frame   = (state == S_B) || (state == S_OP);
   assign timeout_hit = mid_frame && !accept && (idle_cnt == timeout_lim);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idle_cnt  <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= timeout_hit;
         if (!mid_frame || accept || timeout_hit) idle_cnt <= '0;
         else                                    idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// tb/tb_alu_frame_ctrl.sv - directed self-checking bench for alu_frame_ctrl
module tb_alu_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_alu_a, o_alu_b, o_alu_op;
    logic [7:0] alu_res;
    logic [7:0] o_res;
    logic       o_res_valid;
    logic       i_res_ready;
    logic       o_err;
    logic [7:0] o_frame_cnt;
    logic       o_timeout;
    logic       o_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_frame_ctrl #(.nb_data(8), .nb_timeout(16), .timeout_cyc(8)) dut (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .i_alu_res(alu_res),
        .o_res(o_res), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_err(o_err),
        .o_frame_cnt(o_frame_cnt), .o_timeout(o_timeout), .o_busy(o_busy)
    );

    always_comb begin
        case (o_alu_op)
            8'h20:   alu_res = o_alu_a + o_alu_b;
            8'h22:   alu_res = o_alu_a - o_alu_b;
            8'h24:   alu_res = o_alu_a & o_alu_b;
            8'h25:   alu_res = o_alu_a | o_alu_b;
            8'h26:   alu_res = o_alu_a ^ o_alu_b;
            8'h03:   alu_res = 8'($signed(o_alu_a) >>> o_alu_b);
            8'h02:   alu_res = o_alu_a >> o_alu_b;
            8'h27:   alu_res = ~(o_alu_a | o_alu_b);
            default: alu_res = 8'hAA;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!o_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $error("FAIL send_ready observed=%0h expected=1", o_ready);
        end
        i_data  = d;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!o_res_valid && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (o_res_valid !== 1'b1) begin
            errors++;
            $error("FAIL res_valid observed=%0h expected=1", o_res_valid);
        end
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp_res, input logic exp_err, input string tag);
        send(a);
        send(b);
        send(op);
        wait_res();
        checks++;
        if (o_res !== exp_res) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o_res, exp_res);
        end
        checks++;
        if (o_err !== exp_err) begin
            errors++;
            $error("FAIL %s_err observed=%0h expected=%0h", tag, o_err, exp_err);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        i_data      = 8'h00;
        i_valid     = 1'b0;
        i_res_ready = 1'b1;
        step();
        step();
        checks++;
        if (o_res_valid !== 1'b0) begin errors++; $error("FAIL rst_res_valid observed=%0h expected=0", o_res_valid); end
        checks++;
        if (o_frame_cnt !== 8'd0) begin errors++; $error("FAIL rst_cnt observed=%0h expected=0", o_frame_cnt); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $error("FAIL rst_ready observed=%0h expected=1", o_ready); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL rst_busy observed=%0h expected=0", o_busy); end
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $error("FAIL rst_timeout observed=%0h expected=0", o_timeout); end
        reset_n = 1'b1;
        step();

        send(8'h05);
        send(8'h03);
        send(8'h20);
        checks++;
        if (o_res_valid !== 1'b0) begin errors++; $error("FAIL lat_n observed=%0h expected=0", o_res_valid); end
        checks++;
        if (o_ready !== 1'b0) begin errors++; $error("FAIL exec_ready observed=%0h expected=0", o_ready); end
        step();
        checks++;
        if (o_res_valid !== 1'b0) begin errors++; $error("FAIL lat_n1 observed=%0h expected=0", o_res_valid); end
        step();
        checks++;
        if (o_res_valid !== 1'b1) begin errors++; $error("FAIL lat_n2 observed=%0h expected=1", o_res_valid); end
        checks++;
        if (o_res !== 8'h08) begin errors++; $error("FAIL add_res observed=%0h expected=08", o_res); end
        checks++;
        if (o_err !== 1'b0) begin errors++; $error("FAIL add_err observed=%0h expected=0", o_err); end
        step();
        checks++;
        if (o_frame_cnt !== 8'd1) begin errors++; $error("FAIL f1_cnt observed=%0h expected=1", o_frame_cnt); end
        checks++;
        if (o_res_valid !== 1'b0) begin errors++; $error("FAIL f1_valid_clr observed=%0h expected=0", o_res_valid); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL f1_busy observed=%0h expected=0", o_busy); end

        frame(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, "sub_res");
        frame(8'h80, 8'h01, 8'h03, 8'hC0, 1'b0, "sra_res");
        checks++;
        if (o_frame_cnt !== 8'd3) begin errors++; $error("FAIL f3_cnt observed=%0h expected=3", o_frame_cnt); end

        frame(8'h0F, 8'hF0, 8'h11, 8'hAA, 1'b1, "ill_res");
        checks++;
        if (o_err !== 1'b0) begin errors++; $error("FAIL ill_err_clr observed=%0h expected=0", o_err); end
        checks++;
        if (o_res_valid !== 1'b0) begin errors++; $error("FAIL ill_valid_clr observed=%0h expected=0", o_res_valid); end
        checks++;
        if (o_frame_cnt !== 8'd4) begin errors++; $error("FAIL f4_cnt observed=%0h expected=4", o_frame_cnt); end

        i_res_ready = 1'b0;
        send(8'hF0);
        send(8'h0F);
        send(8'h24);
        wait_res();
        i_data  = 8'h55;
        i_valid = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (o_res !== 8'h00) begin errors++; $error("FAIL bp_res observed=%0h expected=00", o_res); end
        checks++;
        if (o_res_valid !== 1'b1) begin errors++; $error("FAIL bp_valid observed=%0h expected=1", o_res_valid); end
        checks++;
        if (o_ready !== 1'b0) begin errors++; $error("FAIL bp_ready observed=%0h expected=0", o_ready); end
        checks++;
        if (o_alu_a !== 8'hF0) begin errors++; $error("FAIL bp_a_hold observed=%0h expected=f0", o_alu_a); end
        checks++;
        if (o_frame_cnt !== 8'd4) begin errors++; $error("FAIL bp_cnt_hold observed=%0h expected=4", o_frame_cnt); end
        i_valid     = 1'b0;
        i_res_ready = 1'b1;
        step();
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL bp_release_busy observed=%0h expected=0", o_busy); end
        checks++;
        if (o_res_valid !== 1'b0) begin errors++; $error("FAIL bp_release_valid observed=%0h expected=0", o_res_valid); end
        checks++;
        if (o_frame_cnt !== 8'd5) begin errors++; $error("FAIL f5_cnt observed=%0h expected=5", o_frame_cnt); end

        send(8'h11);
        send(8'h22);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (o_alu_a !== 8'h00) begin errors++; $error("FAIL mid_rst_a observed=%0h expected=00", o_alu_a); end
        checks++;
        if (o_alu_b !== 8'h00) begin errors++; $error("FAIL mid_rst_b observed=%0h expected=00", o_alu_b); end
        checks++;
        if (o_alu_op !== 8'h00) begin errors++; $error("FAIL mid_rst_op observed=%0h expected=00", o_alu_op); end
        checks++;
        if (o_res !== 8'h00) begin errors++; $error("FAIL mid_rst_res observed=%0h expected=00", o_res); end
        checks++;
        if (o_frame_cnt !== 8'd0) begin errors++; $error("FAIL mid_rst_cnt observed=%0h expected=0", o_frame_cnt); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL mid_rst_busy observed=%0h expected=0", o_busy); end
        frame(8'h01, 8'h01, 8'h27, 8'hFE, 1'b0, "nor_res");
        checks++;
        if (o_frame_cnt !== 8'd1) begin errors++; $error("FAIL nor_cnt observed=%0h expected=1", o_frame_cnt); end

`ifdef ALU_CTRL_TIMEOUT_EN
        send(8'h09);
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 8) begin
                checks++;
                if (o_timeout !== 1'b1) begin errors++; $error("FAIL to_pulse observed=%0h expected=1", o_timeout); end
                checks++;
                if (o_busy !== 1'b0) begin errors++; $error("FAIL to_state_a observed=%0h expected=0", o_busy); end
            end else begin
                checks++;
                if (o_timeout !== 1'b0) begin errors++; $error("FAIL to_quiet observed=%0h expected=0", o_timeout); end
            end
            checks++;
            if (o_ready !== 1'b1) begin errors++; $error("FAIL to_ready observed=%0h expected=1", o_ready); end
        end
        checks++;
        if (o_alu_a !== 8'h09) begin errors++; $error("FAIL to_a_kept observed=%0h expected=09", o_alu_a); end
        checks++;
        if (o_frame_cnt !== 8'd1) begin errors++; $error("FAIL to_cnt_hold observed=%0h expected=1", o_frame_cnt); end
        frame(8'h02, 8'h02, 8'h26, 8'h00, 1'b0, "to_xor_res");
`else
        send(8'h09);
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $error("FAIL nto_timeout observed=%0h expected=0", o_timeout); end
        checks++;
        if (o_busy !== 1'b1) begin errors++; $error("FAIL nto_busy observed=%0h expected=1", o_busy); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $error("FAIL nto_ready observed=%0h expected=1", o_ready); end
        send(8'h02);
        send(8'h26);
        wait_res();
        checks++;
        if (o_res !== 8'h0B) begin errors++; $error("FAIL nto_xor_res observed=%0h expected=0b", o_res); end
        step();
        checks++;
        if (o_frame_cnt !== 8'd2) begin errors++; $error("FAIL nto_cnt observed=%0h expected=2", o_frame_cnt); end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
